// File: rtl/ioctl_sdram_loader.sv
// HPS ioctl download to SDRAM write engine: packs ioctl beats into memory words,
// maps the download index to a region and issues toggle req/ack writes.
module ioctl_sdram_loader #(
  parameter int IOCTL_W     = 16,
  parameter int MEM_W       = 32,
  parameter int ADDR_W      = 25,
  parameter int NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {25'h100000, 25'h0},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE = {25'h100000, 25'h100000}
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ioctl_download,
  input  logic [7:0]         ioctl_index,
  input  logic               ioctl_wr,
  input  logic [IOCTL_W-1:0] ioctl_dout,
  output logic               ioctl_wait,
  output logic               core_active,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [MEM_W-1:0]   mem_din,
  output logic [MEM_W/8-1:0] mem_be,
  output logic               mem_we_req,
  input  logic               mem_we_ack,
  output logic               done,
  output logic               overflow
);
  localparam int R   = MEM_W / IOCTL_W;
  localparam int BW  = (R > 1) ? $clog2(R) : 1;
  localparam int BEW = MEM_W / 8;
  localparam int BPB = IOCTL_W / 8;
  localparam int RW  = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WAIT_ACK, S_FLUSH, S_DONE} state_t;

  state_t            r_state, w_next;
  logic              r_dl_d, r_pend, r_fall, r_ovf, r_req;
  logic [RW-1:0]     r_region, r_pend_region;
  logic [ADDR_W-1:0] r_off, r_waddr;
  logic [BW-1:0]     r_k;
  logic [BEW-1:0]    r_be;
  logic [MEM_W-1:0]  r_din;

  logic              w_idx_ok, w_start, w_fall, w_go, w_accept, w_last, w_ack, w_full;
  logic              w_issue, w_drop, w_flush;
  logic [BW-1:0]     w_kn;
  logic [ADDR_W-1:0] w_base, w_size;
  logic [BEW-1:0]    w_fbe;
  logic              w_unused;

  assign w_unused = ^ioctl_index[7:6];

  assign w_idx_ok = ({2'b00, ioctl_index[5:0]} < 8'(NUM_REGIONS));
  assign w_start  = ioctl_download & ~r_dl_d & w_idx_ok;
  assign w_fall   = ~ioctl_download & r_dl_d;
  // A start that arrives mid-download-tail is held until IDLE/DONE so it is never lost.
  assign w_go     = ((r_state == S_IDLE) || (r_state == S_DONE)) && (w_start || r_pend);
  assign w_accept = (r_state == S_COLLECT) && ioctl_wr;
  assign w_last   = w_accept && (r_k == BW'(R - 1));
  assign w_kn     = r_k + BW'(w_accept);
  assign w_ack    = (mem_we_ack == r_req);
  assign w_full   = (r_off >= w_size);

  always_comb begin
    w_base = '0;
    w_size = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (r_region == RW'(i)) begin
        w_base = REGION_BASE[i*ADDR_W +: ADDR_W];
        w_size = REGION_SIZE[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    w_fbe = '0;
    for (int b = 0; b < BEW; b++) w_fbe[b] = (b < int'(w_kn) * BPB);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_drop  = 1'b0;
    w_flush = 1'b0;
    case (r_state)
      S_IDLE: if (w_go) w_next = S_COLLECT;
      S_COLLECT: begin
        if (w_last) begin
          if (w_full) begin
            w_drop = 1'b1;
            if (w_fall) w_next = S_DONE;
          end else begin
            w_issue = 1'b1;
            w_next  = S_WAIT_ACK;
          end
        end else if (w_fall) begin
          if (w_kn == '0) begin
            w_next = S_DONE;
          end else if (w_full) begin
            w_drop = 1'b1;
            w_next = S_DONE;
          end else begin
            w_flush = 1'b1;
            w_next  = S_FLUSH;
          end
        end
      end
      S_WAIT_ACK: if (w_ack) w_next = (r_fall || w_fall) ? S_DONE : S_COLLECT;
      S_FLUSH:    if (w_ack) w_next = S_DONE;
      S_DONE:     w_next = w_go ? S_COLLECT : S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_dl_d        <= 1'b0;
      r_pend        <= 1'b0;
      r_pend_region <= '0;
      r_region      <= '0;
      r_off         <= '0;
      r_k           <= '0;
      r_fall        <= 1'b0;
      r_ovf         <= 1'b0;
      r_req         <= mem_we_ack;
      r_be          <= '0;
      r_din         <= '0;
      r_waddr       <= '0;
    end else begin
      r_dl_d <= ioctl_download;
      if (w_go) begin
        r_pend   <= 1'b0;
        r_region <= w_start ? ioctl_index[RW-1:0] : r_pend_region;
        r_off    <= '0;
        r_k      <= '0;
        r_fall   <= 1'b0;
        r_ovf    <= 1'b0;
      end else if (w_start) begin
        r_pend        <= 1'b1;
        r_pend_region <= ioctl_index[RW-1:0];
      end
      if (w_accept) begin
        for (int l = 0; l < R; l++)
          if (r_k == BW'(l)) r_din[l*IOCTL_W +: IOCTL_W] <= ioctl_dout;
        r_k <= w_last ? '0 : w_kn;
      end
      if (w_issue || w_flush) begin
        r_req   <= ~r_req;
        r_waddr <= w_base + r_off;
        r_be    <= w_issue ? '1 : w_fbe;
      end
      if (w_drop) r_ovf <= 1'b1;
      if (r_state == S_WAIT_ACK) begin
        if (w_fall) r_fall <= 1'b1;
        if (w_ack)  r_off  <= r_off + ADDR_W'(BEW);
      end
    end
  end

  assign ioctl_wait  = (r_state == S_WAIT_ACK);
  assign core_active = (r_state == S_COLLECT) || (r_state == S_WAIT_ACK) || (r_state == S_FLUSH);
  assign done        = (r_state == S_DONE);
  assign overflow    = r_ovf;
  assign mem_waddr   = r_waddr;
  assign mem_din     = r_din;
  assign mem_be      = r_be;
  assign mem_we_req  = r_req;
endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Directed bench: default config (a), 8-byte region 0 (b), 64-bit word with 8-bit beats (c).
module tb_ioctl_sdram_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] dl = '0, wr = '0, ack = '0, ack_en = '1;
  logic [2:0][7:0] idx = '0;
  logic [15:0] dout_a = '0, dout_b = '0;
  logic [7:0]  dout_c = '0;
  wire  [2:0]  wt, ca, dn, ov, rq;
  wire  [24:0] wa_a, wa_b, wa_c;
  wire  [31:0] din_a, din_b;
  wire  [63:0] din_c;
  wire  [3:0]  be_a, be_b;
  wire  [7:0]  be_c;
  int nw[3] = '{0, 0, 0};
  int ndone[3] = '{0, 0, 0};
  int acnt[3] = '{0, 0, 0};
  logic [2:0] last_req = '0;
  int ntests = 0, nfail = 0;

  always #5 clk = ~clk;

  ioctl_sdram_loader u_a (
    .clk_sys(clk), .reset(rst), .ioctl_download(dl[0]), .ioctl_index(idx[0]), .ioctl_wr(wr[0]),
    .ioctl_dout(dout_a), .ioctl_wait(wt[0]), .core_active(ca[0]), .mem_waddr(wa_a), .mem_din(din_a),
    .mem_be(be_a), .mem_we_req(rq[0]), .mem_we_ack(ack[0]), .done(dn[0]), .overflow(ov[0]));

  ioctl_sdram_loader #(.REGION_SIZE({25'h100000, 25'h8})) u_b (
    .clk_sys(clk), .reset(rst), .ioctl_download(dl[1]), .ioctl_index(idx[1]), .ioctl_wr(wr[1]),
    .ioctl_dout(dout_b), .ioctl_wait(wt[1]), .core_active(ca[1]), .mem_waddr(wa_b), .mem_din(din_b),
    .mem_be(be_b), .mem_we_req(rq[1]), .mem_we_ack(ack[1]), .done(dn[1]), .overflow(ov[1]));

  ioctl_sdram_loader #(.IOCTL_W(8), .MEM_W(64)) u_c (
    .clk_sys(clk), .reset(rst), .ioctl_download(dl[2]), .ioctl_index(idx[2]), .ioctl_wr(wr[2]),
    .ioctl_dout(dout_c), .ioctl_wait(wt[2]), .core_active(ca[2]), .mem_waddr(wa_c), .mem_din(din_c),
    .mem_be(be_c), .mem_we_req(rq[2]), .mem_we_ack(ack[2]), .done(dn[2]), .overflow(ov[2]));

  // SDRAM stand-in: acknowledges each request on the third falling edge after it appears.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) last_req[i] = rq[i];
      else if (rq[i] != last_req[i]) begin
        last_req[i] = rq[i];
        nw[i] = nw[i] + 1;
      end
      if (dn[i]) ndone[i] = ndone[i] + 1;
      if (ack_en[i] && (rq[i] != ack[i])) begin
        acnt[i] = acnt[i] + 1;
        if (acnt[i] == 3) begin
          ack[i]  = rq[i];
          acnt[i] = 0;
        end
      end else acnt[i] = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic beat(input int i, input logic [15:0] d);
    int n = 0;
    while ((wt[i] === 1'b1) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      ntests++;
      nfail++;
      $error("FAIL beat_timeout observed=wait_stuck expected=wait_low");
    end
    case (i)
      0: dout_a = d;
      1: dout_b = d;
      default: dout_c = d[7:0];
    endcase
    wr[i] = 1'b1;
    @(negedge clk);
    wr[i] = 1'b0;
  endtask

  // Wait is high the cycle after the completing beat and through the ack cycle.
  task automatic word_wait(input int i, input string tag);
    chk1({tag, "_wait1"}, wt[i], 1'b1);
    @(negedge clk);
    chk1({tag, "_wait2"}, wt[i], 1'b1);
    @(negedge clk);
    chk1({tag, "_wait3"}, wt[i], 1'b1);
    @(negedge clk);
    chk1({tag, "_wait_rel"}, wt[i], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk1("rst_wait", wt[0], 1'b0);
    chk1("rst_active", ca[0], 1'b0);
    chk1("rst_done", dn[0], 1'b0);
    chk1("rst_ovf", ov[0], 1'b0);
    chk("rst_be", 64'(be_a), 64'h0);
    chk("rst_din", 64'(din_a), 64'h0);
    chk("rst_addr", 64'(wa_a), 64'h0);
    chk1("rst_req", rq[0], ack[0]);
    chk("rst_din_c", din_c, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // index 0, 8 beats -> 4 full words
    idx[0] = 8'd0; dl[0] = 1'b1;
    @(negedge clk);
    chk1("t1_active", ca[0], 1'b1);
    for (int w = 0; w < 4; w++) begin
      beat(0, 16'(2*w + 1));
      beat(0, 16'(2*w + 2));
      chk("t1_addr", 64'(wa_a), 64'(4*w));
      chk("t1_din", 64'(din_a), {32'h0, 16'(2*w + 2), 16'(2*w + 1)});
      chk("t1_be", 64'(be_a), 64'hF);
      word_wait(0, "t1");
    end
    dl[0] = 1'b0;
    @(negedge clk);
    chk1("t1_done", dn[0], 1'b1);
    chk1("t1_inactive", ca[0], 1'b0);
    @(negedge clk);
    chk1("t1_done_once", dn[0], 1'b0);
    chk("t1_nwrites", 64'(nw[0]), 64'd4);
    chk("t1_ndone", 64'(ndone[0]), 64'd1);

    // index 1, 3 beats -> one word then a half-word flush
    idx[0] = 8'd1; dl[0] = 1'b1;
    @(negedge clk);
    chk1("t2_active", ca[0], 1'b1);
    beat(0, 16'h000A);
    beat(0, 16'h000B);
    chk("t2_addr", 64'(wa_a), 64'h100000);
    chk("t2_din", 64'(din_a), 64'h000B000A);
    chk("t2_be", 64'(be_a), 64'hF);
    word_wait(0, "t2");
    beat(0, 16'h000C);
    dl[0] = 1'b0;
    @(negedge clk);
    chk("t2_faddr", 64'(wa_a), 64'h100004);
    chk("t2_fdin", 64'(din_a[15:0]), 64'h000C);
    chk("t2_fbe", 64'(be_a), 64'h3);
    chk1("t2_fwait", wt[0], 1'b0);
    repeat (3) @(negedge clk);
    chk1("t2_done", dn[0], 1'b1);
    @(negedge clk);
    chk("t2_nwrites", 64'(nw[0]), 64'd6);
    chk("t2_ndone", 64'(ndone[0]), 64'd2);

    // 8-byte region: third word dropped, overflow, then restart straight out of DONE
    idx[1] = 8'd0; dl[1] = 1'b1;
    @(negedge clk);
    beat(1, 16'h1);
    beat(1, 16'h2);
    chk("t3_addr0", 64'(wa_b), 64'h0);
    word_wait(1, "t3a");
    beat(1, 16'h3);
    beat(1, 16'h4);
    chk("t3_addr1", 64'(wa_b), 64'h4);
    chk("t3_din1", 64'(din_b), 64'h00040003);
    word_wait(1, "t3b");
    beat(1, 16'h5);
    beat(1, 16'h6);
    chk1("t3_nowait", wt[1], 1'b0);
    chk1("t3_ovf", ov[1], 1'b1);
    chk("t3_nwrites", 64'(nw[1]), 64'd2);
    dl[1] = 1'b0;
    @(negedge clk);
    chk1("t3_done", dn[1], 1'b1);
    dl[1] = 1'b1;
    @(negedge clk);
    chk1("t3_restart", ca[1], 1'b1);
    chk1("t3_ovf_clr", ov[1], 1'b0);
    dl[1] = 1'b0;
    @(negedge clk);
    chk1("t3_done2", dn[1], 1'b1);
    @(negedge clk);

    // out-of-range index is ignored
    idx[0] = 8'd7; dl[0] = 1'b1;
    @(negedge clk);
    chk1("t4_inactive", ca[0], 1'b0);
    for (int i = 0; i < 4; i++) begin
      beat(0, 16'(i + 16'h20));
      chk1("t4_active", ca[0], 1'b0);
      chk1("t4_wait", wt[0], 1'b0);
    end
    dl[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_nwrites", 64'(nw[0]), 64'd6);
    chk("t4_ndone", 64'(ndone[0]), 64'd2);
    chk1("t4_req", rq[0], ack[0]);

    // reset while a write is outstanding and never acknowledged
    ack_en[0] = 1'b0;
    idx[0] = 8'd0; dl[0] = 1'b1;
    @(negedge clk);
    beat(0, 16'h1);
    beat(0, 16'h2);
    chk1("t5_wait", wt[0], 1'b1);
    chk1("t5_pending", rq[0] ^ ack[0], 1'b1);
    @(negedge clk);
    rst = 1'b1; dl[0] = 1'b0;
    @(negedge clk);
    chk1("t5_wait_rst", wt[0], 1'b0);
    chk1("t5_active_rst", ca[0], 1'b0);
    chk1("t5_req_rst", rq[0], ack[0]);
    @(negedge clk);
    rst = 1'b0; ack_en[0] = 1'b1;
    @(negedge clk);
    dl[0] = 1'b1;
    @(negedge clk);
    beat(0, 16'h9);
    beat(0, 16'hA);
    chk("t5_addr", 64'(wa_a), 64'h0);
    chk("t5_din", 64'(din_a), 64'h000A0009);
    word_wait(0, "t5");
    dl[0] = 1'b0;
    @(negedge clk);
    chk1("t5_done", dn[0], 1'b1);
    @(negedge clk);
    chk("t5_nwrites", 64'(nw[0]), 64'd8);

    // 64-bit word, 8-bit beats: 5 beats, last one alongside the download fall
    idx[2] = 8'd0; dl[2] = 1'b1;
    @(negedge clk);
    beat(2, 16'h11);
    beat(2, 16'h22);
    beat(2, 16'h33);
    beat(2, 16'h44);
    wr[2] = 1'b1; dout_c = 8'h55; dl[2] = 1'b0;
    @(negedge clk);
    wr[2] = 1'b0;
    chk("t6_be", 64'(be_c), 64'h1F);
    chk("t6_addr", 64'(wa_c), 64'h0);
    chk("t6_din", 64'(din_c[39:0]), 64'h5544332211);
    chk1("t6_wait", wt[2], 1'b0);
    repeat (3) @(negedge clk);
    chk1("t6_done", dn[2], 1'b1);
    @(negedge clk);
    chk("t6_nwrites", 64'(nw[2]), 64'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
